// File: rtl/mic_volume_meter_pkg.sv
// Shared constants and state type for the microphone front-end blocks.
package mic_pkg;

    localparam int unsigned SAMPLE_W      = 12;
    localparam int unsigned MID_CODE_DEF  = 2048;
    localparam int unsigned MAX_LEVEL_DEF = 16;
    localparam int unsigned LEVEL_W       = 5;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        RUN    = 1'b1
    } state_e;

endpackage

// File: rtl/mic_volume_meter_abs_amplitude.sv
// Combinational distance of an ADC sample from the silence midpoint.
module abs_amplitude
    import mic_pkg::*;
#(
    parameter int unsigned MID_CODE = MID_CODE_DEF
) (
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [SAMPLE_W-1:0] amp_o
);

    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(MID_CODE);

    always_comb begin
        amp_o = (sample_i >= MID) ? (sample_i - MID) : (MID - sample_i);
    end

endmodule

// File: rtl/mic_volume_meter.sv
// Windowed peak meter with instant attack / one-level-per-window decay and LED bar.
module mic_volume_meter
    import mic_pkg::*;
#(
    parameter int unsigned WINDOW_SAMPLES = 4000,
    parameter int unsigned MID_CODE       = MID_CODE_DEF,
    parameter int unsigned LEVEL_SHIFT    = 6,
    parameter int unsigned MAX_LEVEL      = MAX_LEVEL_DEF,
    parameter int unsigned WARMUP_WINDOWS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] mic_in,
    output logic [LEVEL_W-1:0]  volume,
    output logic                volume_valid,
    output logic [15:0]         led,
    output logic                warm
);

    localparam logic [15:0]         WIN_LAST  = 16'(WINDOW_SAMPLES - 1);
    localparam logic [15:0]         WARM_LAST = 16'(WARMUP_WINDOWS - 1);
    localparam logic [SAMPLE_W-1:0] MAX_L_WIDE = SAMPLE_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0]  MAX_L      = LEVEL_W'(MAX_LEVEL);

    logic [SAMPLE_W-1:0] amp;
    logic [SAMPLE_W-1:0] peak_max;
    logic                win_end;
    logic [SAMPLE_W-1:0] raw_full;
    logic [LEVEL_W-1:0]  raw;

    logic [15:0]         cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [SAMPLE_W-1:0] final_q, final_d;
    logic                end_q, end_d;
    state_e              state_q, state_d;
    logic [15:0]         warm_cnt_q, warm_cnt_d;
    logic                warm_q, warm_d;
    logic [LEVEL_W-1:0]  vol_q, vol_d;
    logic                valid_q, valid_d;
    logic [15:0]         led_q, led_d;

    abs_amplitude #(
        .MID_CODE(MID_CODE)
    ) u_abs (
        .sample_i(mic_in),
        .amp_o   (amp)
    );

    // Stage 1: peak tracking; the closing sample's amp joins the window it closes.
    always_comb begin
        peak_max = (amp > peak_q) ? amp : peak_q;
        win_end  = sample_valid && (cnt_q == WIN_LAST);
        cnt_d    = cnt_q;
        peak_d   = peak_q;
        final_d  = final_q;
        end_d    = 1'b0;
        if (sample_valid) begin
            if (win_end) begin
                cnt_d   = '0;
                peak_d  = '0;
                final_d = peak_max;
                end_d   = 1'b1;
            end else begin
                cnt_d  = cnt_q + 16'd1;
                peak_d = peak_max;
            end
        end
    end

    // Stage 2: saturating quantiser, ballistics and LED decode.
    always_comb begin
        raw_full   = final_q >> LEVEL_SHIFT;
        raw        = (raw_full > MAX_L_WIDE) ? MAX_L : raw_full[LEVEL_W-1:0];
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        warm_d     = warm_q;
        vol_d      = vol_q;
        valid_d    = 1'b0;
        unique case (state_q)
            WARMUP: begin
                if (WARMUP_WINDOWS == 0) begin
                    state_d = RUN;
                    warm_d  = 1'b1;
                end else if (end_q) begin
                    warm_cnt_d = warm_cnt_q + 16'd1;
                    if (warm_cnt_q == WARM_LAST) begin
                        state_d = RUN;
                        warm_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (end_q) begin
                    vol_d   = (raw >= vol_q) ? raw : (vol_q - 5'd1);
                    valid_d = 1'b1;
                end
            end
        endcase
        led_d = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            led_d[i] = (LEVEL_W'(i) < vol_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            peak_q     <= '0;
            final_q    <= '0;
            end_q      <= 1'b0;
            state_q    <= WARMUP;
            warm_cnt_q <= '0;
            warm_q     <= 1'b0;
            vol_q      <= '0;
            valid_q    <= 1'b0;
            led_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
            final_q    <= final_d;
            end_q      <= end_d;
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            warm_q     <= warm_d;
            vol_q      <= vol_d;
            valid_q    <= valid_d;
            led_q      <= led_d;
        end
    end

    assign volume       = vol_q;
    assign volume_valid = valid_q;
    assign led          = led_q;
    assign warm         = warm_q;

endmodule

// File: tb/tb_mic_volume_meter.sv
// Self-checking bench: cycle-stepped stimulus against a window-level reference model.
module tb_mic_volume_meter;

    localparam int WIN   = 8;
    localparam int WARMW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_valid;
    logic [11:0] mic_in;
    logic [4:0]  volume;
    logic        volume_valid;
    logic [15:0] led;
    logic        warm;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int win_q[$];
    int warm_wins;
    int exp_vol;
    bit exp_valid;
    bit exp_warm;
    int pend_cnt;
    int pend_peak;

    mic_volume_meter #(
        .WINDOW_SAMPLES(WIN),
        .MID_CODE      (2048),
        .LEVEL_SHIFT   (6),
        .MAX_LEVEL     (16),
        .WARMUP_WINDOWS(WARMW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .mic_in      (mic_in),
        .volume      (volume),
        .volume_valid(volume_valid),
        .led         (led),
        .warm        (warm)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] bar(input int v);
        if (v >= 16) return 16'hFFFF;
        return 16'((1 << v) - 1);
    endfunction

    task automatic model_reset();
        win_q.delete();
        warm_wins = 0;
        exp_vol   = 0;
        exp_valid = 1'b0;
        exp_warm  = 1'b0;
        pend_cnt  = 0;
        pend_peak = 0;
    endtask

    task automatic model_strobe(input int v);
        int amp;
        int pk;
        amp = (v >= 2048) ? v - 2048 : 2048 - v;
        win_q.push_back(amp);
        if (win_q.size() == WIN) begin
            pk = 0;
            foreach (win_q[k]) if (win_q[k] > pk) pk = win_q[k];
            win_q.delete();
            pend_cnt  = 2;
            pend_peak = pk;
        end
    endtask

    task automatic close_window(input int pk);
        int raw;
        if (warm_wins < WARMW) begin
            warm_wins++;
            if (warm_wins == WARMW) exp_warm = 1'b1;
        end else begin
            raw = pk / 64;
            if (raw > 16) raw = 16;
            exp_vol   = (raw >= exp_vol) ? raw : exp_vol - 1;
            exp_valid = 1'b1;
        end
    endtask

    task automatic step(input bit sv, input int v, input bit r);
        @(negedge clk);
        exp_valid = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) close_window(pend_peak);
        end
        check_eq("volume", 32'(volume), 32'(exp_vol));
        check_eq("volume_valid", 32'(volume_valid), 32'(exp_valid));
        check_eq("led", 32'(led), 32'(bar(exp_vol)));
        check_eq("warm", 32'(warm), 32'(exp_warm));
        rst          = r;
        sample_valid = sv;
        mic_in       = 12'(v);
        if (r) model_reset();
        else if (sv) model_strobe(v);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, int'($urandom_range(4095, 0)), 1'b0);
    endtask

    task automatic send(input int v, input int maxgap);
        step(1'b1, v, 1'b0);
        if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
    endtask

    task automatic rand_window(input int maxgap);
        int s;
        int d;
        int v;
        s = int'($urandom_range(2047, 0));
        for (int i = 0; i < WIN; i++) begin
            d = int'($urandom_range(s, 0));
            v = ($urandom_range(1, 0) == 1) ? 2048 + d : 2048 - d;
            if (v > 4095) v = 4095;
            send(v, maxgap);
        end
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        mic_in       = '0;
        model_reset();
        repeat (3) step(1'b0, 0, 1'b1);
        check_eq("reset_vol", 32'(volume), 32'd0);
        check_eq("reset_led", 32'(led), 32'h0);

        // Warm-up: two windows of a loud tone must not move volume
        for (int i = 0; i < 2 * WIN; i++) send(3000, 2);
        idle(3);
        check_eq("warm_done", 32'(warm), 32'd1);
        check_eq("warm_vol", 32'(volume), 32'd0);

        // Constant amplitude 700
        for (int i = 0; i < WIN; i++) send(2048 + 700, 1);
        idle(3);
        check_eq("vol700", 32'(volume), 32'd10);
        check_eq("led700", 32'(led), 32'h03FF);

        // Single full-scale negative sample saturates
        send(0, 1);
        for (int i = 1; i < WIN; i++) send(2048, 1);
        idle(3);
        check_eq("vol_sat", 32'(volume), 32'd16);
        check_eq("led_sat", 32'(led), 32'hFFFF);

        // Silent windows decay one level each, then floor at 0
        for (int w = 0; w < 17; w++)
            for (int i = 0; i < WIN; i++) send(2048, 1);
        idle(3);
        check_eq("vol_floor", 32'(volume), 32'd0);

        // Back-to-back strobes, peak on the last slot of window 2
        for (int i = 0; i < 3 * WIN; i++)
            send((i == 2 * WIN - 1) ? 2048 + 900 : 2048, 0);
        idle(3);
        check_eq("b2b_decay", 32'(volume), 32'd13);

        // Randomised windows, with and without gaps
        for (int w = 0; w < 24; w++) rand_window((w % 3 == 0) ? 0 : 2);
        idle(3);

        // Reset one cycle after the window-closing strobe
        for (int i = 0; i < WIN - 1; i++) send(2048 + 300, 1);
        step(1'b1, 2048 + 1000, 1'b0);
        step(1'b0, 0, 1'b1);
        idle(4);
        check_eq("rst_warm", 32'(warm), 32'd0);
        check_eq("rst_vol", 32'(volume), 32'd0);

        // Warm-up repeats, then normal measurement resumes
        for (int i = 0; i < 2 * WIN; i++) send(3500, 1);
        for (int w = 0; w < 6; w++) rand_window(1);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
